// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: machine word, arbiter state,
// port-select encoding and the per-port access bundle.
package dmem_arbiter_pkg;

  // Machine word width used by every data port and by the memory array.
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // CPU_PRI is the normal CPU-priority mode. DBG_FORCE marks the single
  // cycle that follows a bounded-wait forced grant to the debug port.
  typedef enum logic {
    CPU_PRI   = 1'b0,
    DBG_FORCE = 1'b1
  } arbState_e;

  // Which port owns the memory this cycle. The same encoding tags the
  // read return in flight.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_DBG  = 2'd2
  } portSel_e;

  // One port's access request: write flag, byte address, write data.
  typedef struct packed {
    logic  we;
    word_t addr;
    word_t wdata;
  } access_t;

endpackage

// File: rtl/dmem_arbiter_ram.sv
// Single-port data memory: synchronous write, synchronous read, no reset.
module dmem_ram #(
  parameter int DEPTH_LOG2 = 18,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  // Write or read the addressed word on the clock edge.
  // NOTE: the array and its read register have no reset; a reset on a memory
  // turns it into flops and the owner's rvalid already masks stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and the
// debug/loader port. The CPU normally wins; a debug request that has waited
// MAX_WAIT cycles takes the next cycle and stalls the CPU once.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DMEM_POWER = 18,
  parameter int MAX_WAIT   = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  cpu_req,
  input  logic  cpu_we,
  input  word_t cpu_addr,
  input  word_t cpu_wdata,
  output logic  cpu_stall,
  output logic  cpu_rvalid,
  output word_t cpu_rdata,
  input  logic  dbg_req,
  input  logic  dbg_we,
  input  word_t dbg_addr,
  input  word_t dbg_wdata,
  output logic  dbg_gnt,
  output logic  dbg_rvalid,
  output word_t dbg_rdata,
  output logic  misalign_err
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  arbState_e             state;
  logic [7:0]            waitCnt;
  logic                  forceGrant;
  logic                  cpuGrant;
  logic                  dbgGrant;
  portSel_e              grantSel;
  portSel_e              rdOwnerQ;
  logic                  rdMisalignQ;
  access_t               cpuAcc;
  access_t               dbgAcc;
  access_t               grantAcc;
  logic                  misaligned;
  logic                  ramWe;
  logic                  ramRe;
  logic [DMEM_POWER-1:0] ramAddr;
  word_t                 ramRdata;
  word_t                 rdReturn;
  word_t                 cpuHoldQ;
  word_t                 dbgHoldQ;
  logic                  unusedAddrBits;

  assign cpuAcc = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbgAcc = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

  // Pick this cycle's owner: DBG only when the CPU is idle or DBG has waited
  // out its full budget; a forced grant cannot repeat on the following cycle.
  // NOTE: every variable gets a default before any branch so no latch appears.
  always_comb begin
    forceGrant = dbg_req && (waitCnt == WAIT_LIMIT) && (state == CPU_PRI);
    dbgGrant   = dbg_req && (!cpu_req || forceGrant);
    cpuGrant   = cpu_req && !dbgGrant;
    grantSel   = SEL_NONE;
    if (dbgGrant) begin
      grantSel = SEL_DBG;
    end else if (cpuGrant) begin
      grantSel = SEL_CPU;
    end
    grantAcc = dbgGrant ? dbgAcc : cpuAcc;
  end

  assign cpu_stall = cpu_req && !cpuGrant;
  assign dbg_gnt   = dbgGrant;

  // Word index wraps: address bits above the memory depth are ignored.
  assign misaligned     = grantAcc.addr[1:0] != 2'b00;
  assign ramAddr        = grantAcc.addr[DMEM_POWER+1:2];
  assign unusedAddrBits = ^grantAcc.addr[WORD_W-1:DMEM_POWER+2];

  // Misaligned writes are dropped, and nothing is written while reset is low.
  assign ramWe = (grantSel != SEL_NONE) && grantAcc.we && !misaligned && reset;
  assign ramRe = (grantSel != SEL_NONE) && !grantAcc.we && !misaligned;

  dmem_ram #(
    .DEPTH_LOG2(DMEM_POWER),
    .WIDTH     (WORD_W)
  ) u_ram (
    .clk  (clk),
    .we   (ramWe),
    .re   (ramRe),
    .addr (ramAddr),
    .wdata(grantAcc.wdata),
    .rdata(ramRdata)
  );

  // Arbiter state, DBG wait counter and the registered read-return tags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CPU_PRI;
      waitCnt      <= '0;
      rdOwnerQ     <= SEL_NONE;
      rdMisalignQ  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state <= forceGrant ? DBG_FORCE : CPU_PRI;
      if (dbg_req && !dbgGrant) begin
        waitCnt <= (waitCnt == WAIT_LIMIT) ? waitCnt : waitCnt + 8'd1;
      end else begin
        waitCnt <= '0;
      end
      rdOwnerQ     <= (grantSel != SEL_NONE && !grantAcc.we) ? grantSel : SEL_NONE;
      rdMisalignQ  <= misaligned;
      misalign_err <= (grantSel != SEL_NONE) && misaligned;
    end
  end

  // A misaligned read returns zero instead of the memory word.
  assign rdReturn = rdMisalignQ ? '0 : ramRdata;

  // Capture each port's returned word so rdata holds while rvalid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpuHoldQ <= '0;
      dbgHoldQ <= '0;
    end else begin
      if (rdOwnerQ == SEL_CPU) begin
        cpuHoldQ <= rdReturn;
      end
      if (rdOwnerQ == SEL_DBG) begin
        dbgHoldQ <= rdReturn;
      end
    end
  end

  assign cpu_rvalid = (rdOwnerQ == SEL_CPU);
  assign dbg_rvalid = (rdOwnerQ == SEL_DBG);
  assign cpu_rdata  = cpu_rvalid ? rdReturn : cpuHoldQ;
  assign dbg_rdata  = dbg_rvalid ? rdReturn : dbgHoldQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run, all compared against a word-level reference model of the memory and
// the arbitration rules.
module tb_dmem_arbiter;

  localparam int DMEM_POWER = 10;
  localparam int MAX_WAIT   = 8;
  localparam int DEPTH      = 1 << DMEM_POWER;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, misalign_err;
  logic [31:0] cpu_rdata, dbg_rdata;

  dmem_arbiter #(.DMEM_POWER(DMEM_POWER), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_stall   (cpu_stall),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: memory as a sparse word array, DBG wait as a plain count.
  logic [31:0] m_mem [int];
  int          m_wait;
  bit          g_cpu, g_dbg, e_stall, e_gnt;
  bit          e_crv, e_drv, e_mis, e_cknown, e_dknown;
  logic [31:0] e_crd, e_drd;

  function automatic void model_reset();
    m_wait   = 0;
    e_crv    = 0;
    e_drv    = 0;
    e_mis    = 0;
    e_crd    = 32'h0;
    e_drd    = 32'h0;
    e_cknown = 1;
    e_dknown = 1;
  endfunction

  // Drive one cycle of requests (called at the falling edge) and predict grants.
  task automatic apply(input bit creq, input bit cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input bit dreq, input bit dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    #1;
    g_dbg   = dreq && (!creq || m_wait == MAX_WAIT);
    g_cpu   = creq && !g_dbg;
    e_stall = creq && !g_cpu;
    e_gnt   = g_dbg;
  endtask

  // Advance one clock and update the model with the granted access.
  task automatic tick();
    bit any, we, mis, known;
    logic [31:0] a, wd, rd;
    int w;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      any = g_cpu || g_dbg;
      a   = g_dbg ? dbg_addr : cpu_addr;
      we  = g_dbg ? dbg_we : cpu_we;
      wd  = g_dbg ? dbg_wdata : cpu_wdata;
      w   = int'(a[DMEM_POWER+1:2]);
      mis = any && (a[1:0] != 2'b00);
      e_mis = mis;
      e_crv = g_cpu && !we;
      e_drv = g_dbg && !we;
      if (any && we && !mis) m_mem[w] = wd;
      if (any && !we) begin
        known = mis || m_mem.exists(w);
        rd    = mis ? 32'h0 : (m_mem.exists(w) ? m_mem[w] : 32'h0);
        if (g_cpu) begin e_crd = rd; e_cknown = known; end
        else       begin e_drd = rd; e_dknown = known; end
      end
      if (dbg_req && !g_dbg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                   m_wait = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    if ($urandom_range(0, 1) == 1) a = a + 32'(DEPTH * 4);
    return a;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if ({cpu_stall, dbg_gnt, cpu_rvalid, dbg_rvalid, misalign_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000", {cpu_stall, dbg_gnt, cpu_rvalid, dbg_rvalid, misalign_err});
    end
    n_vec++; if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got cpu %h dbg %h want 0", cpu_rdata, dbg_rdata);
    end
    tick();
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL idle_stall: got %b want 0", cpu_stall);
    end
    tick();
    n_vec++; if ({cpu_rvalid, dbg_rvalid, misalign_err} !== 3'b0) begin
      n_err++; $display("FAIL idle_flags: got %b want 000", {cpu_rvalid, dbg_rvalid, misalign_err});
    end
  endtask

  task automatic test_cpu_rw();
    apply(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0);
    n_vec++; if (cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL cpu_write_stall: got %b want 0", cpu_stall);
    end
    tick();
    apply(1, 0, 32'h40, 0, 0, 0, 0, 0);
    n_vec++; if (cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL cpu_read_stall: got %b want 0", cpu_stall);
    end
    tick();
    n_vec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL cpu_read_data: got v=%b %h want v=1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL cpu_rdata_hold: got v=%b %h want v=0 deadbeef", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_dbg_write();
    apply(0, 0, 0, 0, 1, 1, 32'h100, 32'h12345678);
    n_vec++; if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL dbg_idle_grant: got gnt=%b stall=%b want gnt=1 stall=0", dbg_gnt, cpu_stall);
    end
    tick();
    n_vec++; if (dbg_rvalid !== 1'b0) begin
      n_err++; $display("FAIL dbg_write_rvalid: got %b want 0", dbg_rvalid);
    end
    apply(1, 0, 32'h100, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin
      n_err++; $display("FAIL cpu_sees_dbg_write: got v=%b %h want v=1 12345678", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_misalign();
    apply(1, 1, 32'h43, 32'hAAAAAAAA, 0, 0, 0, 0);
    tick();
    n_vec++; if (misalign_err !== 1'b1) begin
      n_err++; $display("FAIL misalign_write_err: got %b want 1", misalign_err);
    end
    apply(1, 0, 32'h40, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (misalign_err !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL misalign_write_suppressed: got err=%b %h want err=0 deadbeef", misalign_err, cpu_rdata);
    end
    apply(1, 0, 32'h41, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0 || misalign_err !== 1'b1) begin
      n_err++; $display("FAIL misalign_read: got v=%b %h err=%b want v=1 0 err=1", cpu_rvalid, cpu_rdata, misalign_err);
    end
  endtask

  // CPU and DBG both read every cycle: DBG must win exactly on cycles 9 and 18.
  task automatic test_starvation();
    bit exp_g;
    for (int i = 0; i < 20; i++) begin
      exp_g = (i == MAX_WAIT) || (i == 2 * MAX_WAIT + 1);
      apply(1, 0, 32'h40, 0, 1, 0, 32'h100, 0);
      n_vec++; if (dbg_gnt !== exp_g || cpu_stall !== exp_g) begin
        n_err++; $display("FAIL starve_cycle%0d: got gnt=%b stall=%b want %b", i, dbg_gnt, cpu_stall, exp_g);
      end
      tick();
      n_vec++; if (exp_g ? (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h12345678 || cpu_rvalid !== 1'b0)
                         : (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dbg_rvalid !== 1'b0)) begin
        n_err++; $display("FAIL starve_return%0d: got cv=%b %h dv=%b %h", i, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata);
      end
    end
  endtask

  // Aliased write through the wrapped address, then reads every cycle.
  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] want  [3];
    addrs[0] = 32'h40;  addrs[1] = 32'h100;       addrs[2] = 32'h40 + 32'(DEPTH * 4);
    want[0]  = 32'hCAFEF00D; want[1] = 32'h12345678; want[2] = 32'hCAFEF00D;
    apply(1, 1, 32'h40 + 32'(DEPTH * 4), 32'hCAFEF00D, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, addrs[i], 0, 0, 0, 0, 0);
      tick();
      n_vec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== want[i]) begin
        n_err++; $display("FAIL b2b_read%0d: got v=%b %h want v=1 %h", i, cpu_rvalid, cpu_rdata, want[i]);
      end
    end
  endtask

  task automatic test_reset_midread();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 32'h40, 0, 1, 0, 32'h100, 0);
      tick();
    end
    apply(1, 0, 32'h40, 0, 1, 0, 32'h100, 0);
    #2 reset = 1'b0;
    #1;
    n_vec++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
      n_err++; $display("FAIL async_reset_clear: got v=%b %h want v=0 0", cpu_rvalid, cpu_rdata);
    end
    tick();
    apply(1, 1, 32'h40, 32'h55555555, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || misalign_err !== 1'b0) begin
      n_err++; $display("FAIL post_reset_rvalid: got cv=%b dv=%b err=%b want 0", cpu_rvalid, dbg_rvalid, misalign_err);
    end
    apply(1, 0, 32'h40, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (cpu_rdata !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL write_during_reset: got %h want cafef00d", cpu_rdata);
    end
    for (int i = 0; i <= MAX_WAIT; i++) begin
      apply(1, 0, 32'h40, 0, 1, 0, 32'h100, 0);
      n_vec++; if (dbg_gnt !== (i == MAX_WAIT)) begin
        n_err++; $display("FAIL post_reset_wait%0d: got gnt=%b want %b", i, dbg_gnt, i == MAX_WAIT);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] ca, da;
    for (int k = 0; k < 8; k++) begin
      apply(1, 1, 32'h200 + 32'(4 * k), $urandom, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      ca = rand_addr();
      da = rand_addr();
      apply($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), ca, $urandom,
            $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)), da, $urandom);
      n_vec++; if (cpu_stall !== e_stall || dbg_gnt !== e_gnt) begin
        n_err++; $display("FAIL rand_arb%0d: got stall=%b gnt=%b want %b %b", i, cpu_stall, dbg_gnt, e_stall, e_gnt);
      end
      tick();
      n_vec++; if (cpu_rvalid !== e_crv || dbg_rvalid !== e_drv || misalign_err !== e_mis) begin
        n_err++; $display("FAIL rand_flags%0d: got cv=%b dv=%b err=%b want %b %b %b", i,
                          cpu_rvalid, dbg_rvalid, misalign_err, e_crv, e_drv, e_mis);
      end
      n_vec++; if ((e_cknown && cpu_rdata !== e_crd) || (e_dknown && dbg_rdata !== e_drd)) begin
        n_err++; $display("FAIL rand_data%0d: got cpu %h dbg %h want %h %h", i, cpu_rdata, dbg_rdata, e_crd, e_drd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_dbg_write();
    test_misalign();
    test_starvation();
    test_back_to_back();
    test_reset_midread();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Owns the single-port data memory and shares it between the pipeline memory stage (CPU port) and a debug/loader port (DBG port). One access per cycle is granted; the CPU has priority, but a bounded-wait counter guarantees DBG forward progress by stalling the CPU for one cycle when DBG has waited too long. Read data returns one cycle after grant on the granted port, with a valid strobe.

## Interface
- DMEM_POWER, 18, log2 of memory depth in words
- MAX_WAIT, 8, cycles DBG may wait before a forced grant (legal 1..255)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  `WORD  byte address
- cpu_wdata  in  `WORD  write data
- cpu_stall  out  1  CPU request not granted this cycle; pipeline must hold
- cpu_rvalid  out  1  cpu_rdata valid (read granted previous cycle)
- cpu_rdata  out  `WORD  read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/`WORD/`WORD  same meaning for DBG
- dbg_gnt  out  1  DBG request accepted this cycle
- dbg_rvalid, dbg_rdata  out  1/`WORD  DBG read return
- misalign_err  out  1  registered pulse: a granted access had addr[1:0] != 0

## Operation
- Word index = addr >> 2, truncated to DMEM_POWER bits (high bits ignored, wrap-around).
- Arbitration, combinational, each cycle:
  - force = dbg_req && (wait_cnt == MAX_WAIT).
  - DBG granted if dbg_req && (!cpu_req || force); else CPU granted if cpu_req.
  - cpu_stall = cpu_req && !cpu_grant; dbg_gnt = dbg grant.
- FSM, 2 states: CPU_PRI (normal) and DBG_FORCE (entered when force is granted; lasts exactly one cycle, then back to CPU_PRI). In DBG_FORCE, wait_cnt is already 0 and a second consecutive force is impossible; next DBG grant needs an idle CPU cycle or another MAX_WAIT wait.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle dbg_req && !dbg_gnt; cleared on dbg_gnt or when dbg_req is low.
- Granted write: RAM[word] <= wdata at the clock edge. Granted read: synchronous RAM read; rdata/rvalid of the owning port valid the next cycle.
- Misaligned (addr[1:0] != 0) granted access: write suppressed, read returns 0 with rvalid still 1, misalign_err pulses next cycle. Grant and stall behave normally.
- Same-port read one cycle after write to same word returns the new data; read and write never collide (one grant per cycle).
- rdata holds its last value when rvalid is 0.

## Timing
- Reset (reset low, async): state = CPU_PRI, wait_cnt = 0, cpu_rvalid = dbg_rvalid = 0, cpu_rdata = dbg_rdata = 0, misalign_err = 0. RAM contents not reset.
- Reset asserted mid-read: return lost, rvalid stays 0 after release; no write occurs on an edge where reset is low.
- cpu_stall, dbg_gnt: combinational, same cycle as request.
- Read latency 1 cycle from grant; back-to-back reads on one port give rvalid every cycle.
- Worst-case DBG wait with continuous CPU traffic: MAX_WAIT cycles, grant on cycle MAX_WAIT+1.

## Structure
- Shared package: arbiter state enum (CPU_PRI, DBG_FORCE) and port-select encoding; `WORD from the global defines.
- Sub-module dmem_ram: DMEM_POWER-deep, `WORD-wide single-port RAM, synchronous write and read, no reset; arbiter muxes address/we/wdata into it and steers its output to the owning port.

## Test plan
- After reset: all outputs 0, cpu_stall 0 with no requests.
- CPU write 0xDEADBEEF to addr 0x40, then read 0x40 -> cpu_rvalid next cycle, cpu_rdata 0xDEADBEEF, no stall.
- CPU and DBG request together continuously, MAX_WAIT=8 -> cpu_stall 0 for 8 cycles, on 9th dbg_gnt=1 and cpu_stall=1, then CPU resumes; DBG forced again 8 cycles later.
- DBG write 0x12345678 to 0x100 while CPU idle -> dbg_gnt same cycle; CPU read 0x100 next cycle returns 0x12345678.
- CPU write to 0x43 -> misalign_err pulse, RAM word 0x10 unchanged; read of 0x41 returns 0 with rvalid 1.
- Assert reset low during a granted read -> cpu_rvalid stays 0, state CPU_PRI, wait_cnt 0 after release.
